// File: rtl/spi_pkg.sv
// spi_pkg: shared mode type and constants for the SPI slave FIFO block
package spi_pkg;
    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;
    localparam int          SYNC_STAGES       = 2;
    localparam logic [31:0] IDLE_FILL_DEFAULT = 32'h0;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with occupancy output
module sync_fifo #(
    parameter  int DATA_WIDTH = 8,
    parameter  int FIFO_DEPTH = 16,
    localparam int AW         = $clog2(FIFO_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [AW:0]           o_level
);
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]           cnt_q, cnt_d;
    logic                  do_push, do_pop;

    assign o_full  = cnt_q == (AW+1)'(FIFO_DEPTH);
    assign o_empty = cnt_q == '0;
    assign o_level = cnt_q;
    assign o_data  = mem_q[rptr_q];
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);

    // advance pointers and occupancy on accepted push/pop
    always_comb begin
        wptr_d = wptr_q + AW'(do_push);
        rptr_d = rptr_q + AW'(do_pop);
        cnt_d  = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // pointer and occupancy registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // storage, written only on accepted push
    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wptr_q] <= i_data;
    end
endmodule

// File: rtl/spi_slave_fifo.sv
// spi_slave_fifo: SPI slave (all four modes) with TX/RX FIFOs and sticky error flags
module spi_slave_fifo
    import spi_pkg::*;
#(
    parameter  int                    DATA_WIDTH = 8,
    parameter  int                    FIFO_DEPTH = 16,
    parameter  logic [DATA_WIDTH-1:0] IDLE_FILL  = IDLE_FILL_DEFAULT[DATA_WIDTH-1:0],
    localparam int                    LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_sclk,
    input  logic                  i_cs_n,
    input  logic                  i_mosi,
    output logic                  o_miso,
    output logic                  o_miso_oe,
    input  logic                  i_cpol,
    input  logic                  i_cpha,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic                  i_tx_valid,
    output logic                  o_tx_ready,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_rx_valid,
    input  logic                  i_rx_ready,
    output logic [LW-1:0]         o_tx_level,
    output logic [LW-1:0]         o_rx_level,
    output logic                  o_busy,
    output logic                  o_rx_overrun,
    output logic                  o_tx_underrun,
    input  logic                  i_clr_err
);
    localparam int BW = $clog2(DATA_WIDTH);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, cs_sync_q, cs_sync_d, mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES:0]   warm_q, warm_d;
    logic                   sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d;
    logic                   armed_q, armed_d, active_q, active_d;
    spi_mode_t              mode_q, mode_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]  rx_sr_q, rx_sr_d, tx_sr_q, tx_sr_d, rx_word_q, rx_word_d;
    logic                   rx_push_q, rx_push_d, miso_q, miso_d, ovr_q, ovr_d, udr_q, udr_d;

    logic                   sclk_s, cs_s, mosi_s, rise, fall, lead, trail, sample_e, shift_e;
    logic                   start, in_frame, word_done, load, cpha_l, tx_pop, rx_pop;
    logic                   tx_full, tx_empty, rx_full, rx_empty;
    logic [DATA_WIDTH-1:0]  tx_head, load_word;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign rise      = sclk_s && !sclk_prev_q;
    assign fall      = !sclk_s && sclk_prev_q;
    // a frame only starts on a CS fall seen after CS was genuinely observed high
    assign start     = cs_prev_q && !cs_s && armed_q;
    assign in_frame  = active_q && !cs_s;
    assign lead      = in_frame && (mode_q.cpol ? fall : rise);
    assign trail     = in_frame && (mode_q.cpol ? rise : fall);
    assign sample_e  = mode_q.cpha ? trail : lead;
    assign shift_e   = mode_q.cpha ? lead : trail;
    assign word_done = sample_e && bit_cnt_q == BW'(DATA_WIDTH - 1);
    assign load      = start || word_done;
    assign cpha_l    = start ? i_cpha : mode_q.cpha;
    assign load_word = tx_empty ? IDLE_FILL : tx_head;
    assign tx_pop    = load && !tx_empty;
    assign rx_pop    = !rx_empty && i_rx_ready;

    assign o_busy        = in_frame;
    assign o_miso_oe     = in_frame;
    assign o_miso        = miso_q && in_frame;
    assign o_tx_ready    = !tx_full;
    assign o_rx_valid    = !rx_empty;
    assign o_rx_overrun  = ovr_q;
    assign o_tx_underrun = udr_q;

    // synchronizers, frame tracking, shift registers and error flags
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], i_sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], i_cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        warm_d      = {warm_q[SYNC_STAGES-1:0], 1'b1};
        armed_d     = armed_q || (&warm_q && cs_s);
        active_d    = cs_s ? 1'b0 : (start ? 1'b1 : active_q);
        mode_d      = start ? spi_mode_t'({i_cpol, i_cpha}) : mode_q;
        bit_cnt_d   = !in_frame ? '0 : word_done ? '0 : sample_e ? bit_cnt_q + BW'(1) : bit_cnt_q;
        rx_sr_d     = !in_frame ? '0 : sample_e ? {rx_sr_q[DATA_WIDTH-2:0], mosi_s} : rx_sr_q;
        rx_word_d   = word_done ? {rx_sr_q[DATA_WIDTH-2:0], mosi_s} : rx_word_q;
        rx_push_d   = word_done;
        tx_sr_d     = tx_sr_q;
        miso_d      = miso_q;
        if (load) begin
            tx_sr_d = cpha_l ? load_word : {load_word[DATA_WIDTH-2:0], 1'b0};
            miso_d  = cpha_l ? miso_q : load_word[DATA_WIDTH-1];
        end else if (!in_frame) begin
            tx_sr_d = '0;
            miso_d  = 1'b0;
        end else if (shift_e && (mode_q.cpha || bit_cnt_q != '0)) begin
            tx_sr_d = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
            miso_d  = tx_sr_q[DATA_WIDTH-1];
        end
        ovr_d = (ovr_q && !i_clr_err) || (rx_push_q && rx_full && !rx_pop);
        udr_d = (udr_q && !i_clr_err) || (load && tx_empty);
    end

    // state registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            warm_q      <= '0;
            armed_q     <= 1'b0;
            active_q    <= 1'b0;
            mode_q      <= '0;
            bit_cnt_q   <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            rx_word_q   <= '0;
            rx_push_q   <= 1'b0;
            miso_q      <= 1'b0;
            ovr_q       <= 1'b0;
            udr_q       <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            warm_q      <= warm_d;
            armed_q     <= armed_d;
            active_q    <= active_d;
            mode_q      <= mode_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            rx_word_q   <= rx_word_d;
            rx_push_q   <= rx_push_d;
            miso_q      <= miso_d;
            ovr_q       <= ovr_d;
            udr_q       <= udr_d;
        end
    end

    sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_tx_valid && !tx_full),
        .i_data  (i_tx_data),
        .i_pop   (tx_pop),
        .o_data  (tx_head),
        .o_full  (tx_full),
        .o_empty (tx_empty),
        .o_level (o_tx_level)
    );

    sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (rx_push_q),
        .i_data  (rx_word_q),
        .i_pop   (rx_pop),
        .o_data  (o_rx_data),
        .o_full  (rx_full),
        .o_empty (rx_empty),
        .o_level (o_rx_level)
    );
endmodule

// File: tb/tb_spi_slave_fifo.sv
// tb_spi_slave_fifo: SPI master driver with a queue-based reference model of the slave
module tb_spi_slave_fifo;
    localparam int DEPTH = 16;
    localparam int H     = 6;

    logic       i_clk = 0, i_rst_n, i_sclk, i_cs_n, i_mosi, i_cpol, i_cpha;
    logic       i_tx_valid, i_rx_ready, i_clr_err;
    logic [7:0] i_tx_data, o_rx_data;
    logic       o_miso, o_miso_oe, o_tx_ready, o_rx_valid, o_busy, o_rx_overrun, o_tx_underrun;
    logic [4:0] o_tx_level, o_rx_level;

    int         n_chk = 0, n_err = 0;
    bit         quiet = 0;
    logic [7:0] m_tx[$], m_rx[$], popped[$];
    bit         m_ovr = 0, m_udr = 0;
    logic [7:0] mo_words[32], mi_words[32];

    spi_slave_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sclk(i_sclk), .i_cs_n(i_cs_n), .i_mosi(i_mosi),
        .o_miso(o_miso), .o_miso_oe(o_miso_oe), .i_cpol(i_cpol), .i_cpha(i_cpha),
        .i_tx_data(i_tx_data), .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready),
        .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid), .i_rx_ready(i_rx_ready),
        .o_tx_level(o_tx_level), .o_rx_level(o_rx_level), .o_busy(o_busy),
        .o_rx_overrun(o_rx_overrun), .o_tx_underrun(o_tx_underrun), .i_clr_err(i_clr_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // model of a TX word load: FIFO head, or idle fill with underrun
    function automatic logic [7:0] m_load();
        if (m_tx.size() != 0) return m_tx.pop_front();
        m_udr = 1;
        return 8'h00;
    endfunction

    // whenever the bench is idle, every status output must match the model
    always @(negedge i_clk) begin
        if (quiet) begin
            chk("tx_level", o_tx_level, m_tx.size());
            chk("rx_level", o_rx_level, m_rx.size());
            chk("tx_ready", o_tx_ready, m_tx.size() < DEPTH);
            chk("rx_valid", o_rx_valid, m_rx.size() != 0);
            if (m_rx.size() != 0) chk("rx_data", o_rx_data, m_rx[0]);
            chk("rx_overrun", o_rx_overrun, m_ovr);
            chk("tx_underrun", o_tx_underrun, m_udr);
            chk("idle_pins", {o_busy, o_miso_oe, o_miso}, 0);
        end
    end

    task automatic settle(input int n);
        quiet = 1;
        repeat (n) @(negedge i_clk);
        quiet = 0;
    endtask

    task automatic push_tx(input logic [7:0] w);
        chk("push_ready", o_tx_ready, m_tx.size() < DEPTH);
        i_tx_data = w;
        i_tx_valid = 1;
        @(negedge i_clk);
        i_tx_valid = 0;
        m_tx.push_back(w);
    endtask

    task automatic clr_err();
        i_clr_err = 1;
        @(negedge i_clk);
        i_clr_err = 0;
        @(negedge i_clk);
        m_ovr = 0;
        m_udr = 0;
    endtask

    task automatic drain();
        popped.delete();
        while (m_rx.size() != 0) begin
            chk("pop_valid", o_rx_valid, 1);
            chk("pop_data", o_rx_data, m_rx[0]);
            popped.push_back(o_rx_data);
            void'(m_rx.pop_front());
            i_rx_ready = 1;
            @(negedge i_clk);
        end
        i_rx_ready = 0;
    endtask

    task automatic sclk_bit(input logic b);
        i_mosi = b;
        repeat (H) @(negedge i_clk);
        i_sclk = 1;
        repeat (H) @(negedge i_clk);
        i_sclk = 0;
    endtask

    // master: n full words from mo_words, then ab bits of a further word, then CS high
    task automatic frame(input bit pol, input bit pha, input int n, input int ab);
        logic [7:0] cur, got;
        int nb;
        i_cpol = pol;
        i_cpha = pha;
        i_sclk = pol;
        repeat (4) @(negedge i_clk);
        i_cs_n = 0;
        cur = m_load();
        repeat (8) @(negedge i_clk);
        chk("busy_oe", {o_busy, o_miso_oe}, 2'b11);
        i_cpol = 1'($urandom);
        i_cpha = 1'($urandom);
        for (int w = 0; w <= n; w++) begin
            nb = (w < n) ? 8 : ab;
            got = '0;
            for (int b = 7; b >= 8 - nb; b--) begin
                if (pha) i_sclk = ~pol;
                i_mosi = mo_words[w][b];
                repeat (H) @(negedge i_clk);
                got[b] = o_miso;
                i_sclk = pha ? pol : ~pol;
                repeat (H) @(negedge i_clk);
                if (!pha) i_sclk = pol;
            end
            if (w < n) begin
                chk("miso_word", got, cur);
                mi_words[w] = got;
                if (m_rx.size() < DEPTH) m_rx.push_back(mo_words[w]);
                else m_ovr = 1;
                cur = m_load();
            end
        end
        repeat (H) @(negedge i_clk);
        i_cs_n = 1;
        repeat (10) @(negedge i_clk);
    endtask

    initial begin
        int np, nw, md, ab;
        i_rst_n = 0; i_sclk = 0; i_cs_n = 1; i_mosi = 0; i_cpol = 0; i_cpha = 0;
        i_tx_valid = 0; i_tx_data = 0; i_rx_ready = 0; i_clr_err = 0;
        repeat (3) @(negedge i_clk);
        chk("rst_pins", {o_miso, o_miso_oe, o_busy, o_rx_valid, o_tx_ready}, 5'b00001);
        chk("rst_levels", {o_tx_level, o_rx_level}, 0);
        chk("rst_errs", {o_rx_overrun, o_tx_underrun}, 0);
        i_rst_n = 1;
        settle(5);

        // mode 0, two words in one frame
        push_tx(8'hA5); push_tx(8'h3C); push_tx(8'h00);
        mo_words[0] = 8'h12; mo_words[1] = 8'h34;
        frame(0, 0, 2, 0);
        chk("m0_miso0", mi_words[0], 8'hA5);
        chk("m0_miso1", mi_words[1], 8'h3C);
        settle(4);
        drain();
        chk("m0_rx0", popped[0], 8'h12);
        chk("m0_rx1", popped[1], 8'h34);
        settle(3);

        // modes 1..3
        for (int m = 1; m < 4; m++) begin
            push_tx(8'h5A); push_tx(8'h00);
            mo_words[0] = 8'hC3;
            frame(m[1], m[0], 1, 0);
            chk("mode_miso", mi_words[0], 8'h5A);
            chk("mode_rx", o_rx_data, 8'hC3);
            chk("mode_errs", {o_rx_overrun, o_tx_underrun}, 0);
            settle(3);
            drain();
        end

        // TX underrun
        mo_words[0] = 8'($urandom); mo_words[1] = 8'($urandom);
        frame(0, 0, 2, 0);
        chk("udr_miso0", mi_words[0], 8'h00);
        chk("udr_miso1", mi_words[1], 8'h00);
        chk("udr_flag", o_tx_underrun, 1);
        settle(3);
        clr_err();
        chk("udr_clr", o_tx_underrun, 0);
        settle(3);
        drain();

        // RX overrun
        for (int k = 0; k <= DEPTH; k++) mo_words[k] = 8'($urandom);
        frame(0, 0, DEPTH + 1, 0);
        chk("ovr_level", o_rx_level, 16);
        chk("ovr_flag", o_rx_overrun, 1);
        settle(3);
        drain();
        clr_err();
        settle(3);

        // CS abort after 5 bits, then a clean frame
        push_tx(8'h77);
        mo_words[0] = 8'hFF;
        frame(0, 0, 0, 5);
        settle(3);
        mo_words[0] = 8'h81;
        frame(0, 0, 1, 0);
        chk("abort_miso", mi_words[0], 8'h00);
        chk("abort_level", o_rx_level, 1);
        chk("abort_rx", o_rx_data, 8'h81);
        settle(3);
        drain();
        clr_err();
        settle(3);

        // reset pulsed mid-word, then edges while CS still low must be ignored
        push_tx(8'h5A);
        i_cpol = 0; i_cpha = 0; i_sclk = 0;
        repeat (4) @(negedge i_clk);
        i_cs_n = 0;
        repeat (8) @(negedge i_clk);
        for (int k = 0; k < 3; k++) sclk_bit(1);
        i_rst_n = 0;
        #1;
        chk("mrst_pins", {o_miso, o_miso_oe, o_busy, o_rx_valid, o_tx_ready}, 5'b00001);
        chk("mrst_levels", {o_tx_level, o_rx_level}, 0);
        chk("mrst_errs", {o_rx_overrun, o_tx_underrun}, 0);
        m_tx.delete(); m_rx.delete(); m_ovr = 0; m_udr = 0;
        @(negedge i_clk);
        i_rst_n = 1;
        for (int k = 0; k < 9; k++) sclk_bit(k[0]);
        i_cs_n = 1;
        settle(10);
        push_tx(8'hAB); push_tx(8'h00);
        mo_words[0] = 8'hCD;
        frame(0, 0, 1, 0);
        chk("post_rst_miso", mi_words[0], 8'hAB);
        chk("post_rst_rx", o_rx_data, 8'hCD);
        settle(3);
        drain();
        settle(3);

        // randomized frames
        for (int it = 0; it < 12; it++) begin
            np = $urandom_range(0, 4);
            nw = $urandom_range(1, 4);
            md = $urandom_range(0, 3);
            ab = $urandom_range(0, 1) ? 0 : $urandom_range(1, 7);
            for (int k = 0; k < np; k++) if (m_tx.size() < DEPTH) push_tx(8'($urandom));
            for (int k = 0; k < nw; k++) mo_words[k] = 8'($urandom);
            frame(md[1], md[0], nw, ab);
            settle(4);
            if ($urandom_range(0, 1) != 0) clr_err();
            drain();
            settle(2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/spi_slave_fifo.md
SPI_SLAVE_FIFO -- requirements
Module: spi_slave_fifo

Interface
REQ-001 Parameter DATA_WIDTH, 8, bits per SPI word (4..32).
REQ-002 Parameter FIFO_DEPTH, 16, entries per TX and RX FIFO (power of 2, >=2).
REQ-003 Parameter IDLE_FILL, all-zeros, word shifted out on TX underrun.
REQ-004 i_clk  in  1  system clock.
REQ-005 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 i_sclk / i_cs_n / i_mosi  in  1 each  SPI pins, asynchronous to i_clk.
REQ-007 o_miso  out  1  serial data out; o_miso_oe  out  1  high while synced CS low.
REQ-008 i_cpol, i_cpha  in  1 each  SPI mode select.
REQ-009 i_tx_data  in  DATA_WIDTH; i_tx_valid  in  1; o_tx_ready  out  1: TX push handshake.
REQ-010 o_rx_data  out  DATA_WIDTH; o_rx_valid  out  1; i_rx_ready  in  1: RX pop handshake, first-word-fall-through.
REQ-011 o_tx_level, o_rx_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-012 o_busy  out  1  synced CS low; o_rx_overrun, o_tx_underrun  out  1  sticky errors; i_clr_err  in  1  clears both.

Function
REQ-013 i_sclk, i_cs_n, i_mosi SHALL pass 2-FF synchronizers; SCLK edges detected from one further register stage.
REQ-014 i_cpol/i_cpha SHALL be latched on synced CS falling edge; changes mid-frame SHALL have no effect.
REQ-015 Leading edge = SCLK transition away from CPOL level; sample edge = leading if CPHA=0, trailing if CPHA=1; shift edge = the other.
REQ-016 Data SHALL be MSB first; bit counter SHALL count 0..DATA_WIDTH-1 and wrap to 0 after each word; frames of multiple words SHALL be supported under one CS.
REQ-017 On the sample edge completing a word, the word SHALL be pushed into RX FIFO the next i_clk cycle.
REQ-018 RX FIFO full at push with no pop that cycle: word dropped, o_rx_overrun set; push and pop same cycle when full: push accepted.
REQ-019 TX word load SHALL occur at CS falling edge and on the sample edge completing each word; load pops TX FIFO if non-empty, else loads IDLE_FILL and sets o_tx_underrun.
REQ-020 CPHA=0: MSB SHALL drive o_miso within 1 i_clk of load; subsequent bits on shift edges. CPHA=1: MSB driven on first leading edge of the word.
REQ-021 o_tx_ready SHALL equal TX-FIFO-not-full; push when i_tx_valid && o_tx_ready.
REQ-022 o_rx_valid SHALL equal RX-FIFO-not-empty; pop when o_rx_valid && i_rx_ready; o_rx_data stable while o_rx_valid && !i_rx_ready.
REQ-023 CS rising mid-word: partial RX bits discarded, partial TX word discarded (not returned to FIFO), bit counter to 0, o_miso 0, o_busy 0 within 3 i_clk.
REQ-024 SCLK edges while synced CS high SHALL be ignored.
REQ-025 i_clr_err and a same-cycle error event: set wins.
REQ-026 SCLK frequency SHALL be <= i_clk/8 for correct operation.

Reset
REQ-027 Reset SHALL empty both FIFOs, zero bit counter and shift registers, set o_miso=0, o_miso_oe=0, o_busy=0, o_rx_valid=0, o_tx_ready=1, levels=0, errors=0, CS synchronizers to 1, latched mode to 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame; after release, block SHALL wait for a fresh CS falling edge.

Structure
REQ-029 Package spi_pkg SHALL hold spi_mode_t (CPOL/CPHA struct), default IDLE_FILL and synchronizer depth constant.
REQ-030 One sub-module sync_fifo (DATA_WIDTH, FIFO_DEPTH, FWFT, level output) SHALL be instantiated twice for TX and RX.

Verification
REQ-031 Mode 0, TX preloaded 0xA5,0x3C; master sends 0x12,0x34 in one CS -> MISO 0xA5,0x3C; RX pops 0x12,0x34.
REQ-032 Modes 1,2,3 each: master sends 0xC3 with TX 0x5A -> RX 0xC3, MISO 0x5A, no errors.
REQ-033 TX empty, master clocks 2 words -> MISO 0x00,0x00, o_tx_underrun=1; i_clr_err -> 0.
REQ-034 i_rx_ready=0, master sends FIFO_DEPTH+1 words -> o_rx_level=16, o_rx_overrun=1, first 16 words intact.
REQ-035 CS deasserted after 5 bits of 0xFF then new frame 0x81 -> RX contains only 0x81; TX word of aborted frame lost.
REQ-036 Reset pulsed mid-word -> all outputs at REQ-027 values; next full frame transfers correctly.
